reg_write_buffer: RTL

//  Write-side companion of the RegisterFile: queues register-write requests from

---
 rtl/reg_write_buffer_if.sv | 34 +++
 rtl/reg_write_buffer.sv | 117 +++++++++++
 2 files changed

// File: rtl/reg_write_buffer_if.sv
// Write-request / RegisterFile-write / pending-query bundle for reg_write_buffer.
// master = writeback + decode side, slave = the buffer.
interface reg_write_buffer_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) ();
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic              RegWrite;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    logic [ADDR_W-1:0] query_addr_1;
    logic [ADDR_W-1:0] query_addr_2;
    logic              pending_1;
    logic              pending_2;
    logic [DATA_W-1:0] fwd_data_1;
    logic [DATA_W-1:0] fwd_data_2;

    modport master (
        output in_valid, in_addr, in_data, query_addr_1, query_addr_2,
        input  in_ready, RegWrite, write_addr, write_data,
               pending_1, pending_2, fwd_data_1, fwd_data_2
    );

    modport slave (
        input  in_valid, in_addr, in_data, query_addr_1, query_addr_2,
        output in_ready, RegWrite, write_addr, write_data,
               pending_1, pending_2, fwd_data_1, fwd_data_2
    );
endinterface

// File: rtl/reg_write_buffer.sv
// Register-write FIFO draining one entry per cycle onto the RegisterFile write port,
// with a two-port pending-write / youngest-value query for decode forwarding.
module reg_write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input logic               clk,
    input logic               reset,
    reg_write_buffer_if.slave bus
);
    localparam int unsigned     PtrW    = $clog2(DEPTH);
    localparam int unsigned     CntW    = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_mem_q, addr_mem_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem_q, data_mem_d;
    logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]              count_q, count_d;
    logic                         reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]            write_addr_q, write_addr_d;
    logic [DATA_W-1:0]            write_data_q, write_data_d;

    logic in_ready;
    logic push;
    logic pop;

    // A non-empty FIFO drains every edge, so the full check only bites if that ever changes.
    assign in_ready = ~reset & (count_q < FullCnt);
    assign push     = bus.in_valid & in_ready & (bus.in_addr != '0);
    assign pop      = (count_q != '0);

    always_comb begin
        addr_mem_d   = addr_mem_q;
        data_mem_d   = data_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        reg_write_d  = pop;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (push) begin
            addr_mem_d[wr_ptr_q] = bus.in_addr;
            data_mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            write_addr_d = addr_mem_q[rd_ptr_q];
            write_data_d = data_mem_q[rd_ptr_q];
            rd_ptr_d     = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    // Entry validity comes from count/rd_ptr, so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    logic [1:0][ADDR_W-1:0] q_addr;
    logic [1:0]             q_hit;
    logic [1:0][DATA_W-1:0] q_data;
    logic [PtrW-1:0]        idx;

    assign q_addr[0] = bus.query_addr_1;
    assign q_addr[1] = bus.query_addr_2;

    // Oldest source first so that later (younger) matches overwrite earlier ones.
    always_comb begin
        q_hit  = '0;
        q_data = '0;
        idx    = '0;
        for (int p = 0; p < 2; p++) begin
            if (q_addr[p] != '0) begin
                if (reg_write_q && (write_addr_q == q_addr[p])) begin
                    q_hit[p]  = 1'b1;
                    q_data[p] = write_data_q;
                end
                for (int i = 0; i < int'(DEPTH); i++) begin
                    idx = rd_ptr_q + PtrW'(i);
                    if ((CntW'(i) < count_q) && (addr_mem_q[idx] == q_addr[p])) begin
                        q_hit[p]  = 1'b1;
                        q_data[p] = data_mem_q[idx];
                    end
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.RegWrite   = reg_write_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.pending_1  = q_hit[0];
    assign bus.pending_2  = q_hit[1];
    assign bus.fwd_data_1 = q_data[0];
    assign bus.fwd_data_2 = q_data[1];
endmodule
